// File: rtl/dft_capture_pkg.sv
// dft_capture_pkg: shared state encoding, status bit indices and address helper for the scan capture bank
package dft_capture_pkg;
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;
    localparam int ST_BUSY = 16;
    localparam int ST_DONE = 17;
    localparam int ST_OVF = 18;
    function automatic logic [31:0] word_off(input int chain, input int word, input int depth);
        return 32'(depth * chain + word);
    endfunction
endpackage

// File: rtl/dft_capture_lane.sv
// dft_capture_lane: one scan chain buffer with write pointer, fill count, wrap/full tracking and overflow pulse
module dft_capture_lane #(
    parameter int P_DEPTH = 64,
    localparam int AW = $clog2(P_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_capture,
    input  logic          i_mode,
    input  logic [8:0]    i_len,
    input  logic          i_valid,
    input  logic [31:0]   i_data,
    input  logic [AW-1:0] i_rd_word,
    output logic [31:0]   o_rd_data,
    output logic [AW-1:0] o_wp,
    output logic [8:0]    o_count,
    output logic          o_wrapped,
    output logic          o_full,
    output logic          o_full_d,
    output logic          o_ovf
);
    logic [31:0]   r_mem [P_DEPTH];
    logic [AW-1:0] r_wp;
    logic [8:0]    r_count;
    logic          r_wrapped;
    logic          r_full;
    logic          w_acc;
    assign w_acc = i_capture && i_valid && (i_mode || !r_full);
    assign o_ovf = i_capture && i_valid && !i_mode && r_full;
    // the FSM needs the post-write full state so the last write edge can end the capture
    assign o_full_d = r_full || (w_acc && !i_mode && (r_count + 9'd1 == i_len));
    assign o_rd_data = r_mem[i_rd_word];
    assign o_wp = r_wp;
    assign o_count = r_count;
    assign o_wrapped = r_wrapped;
    assign o_full = r_full;
    always_ff @(posedge clk) begin
        if (w_acc) r_mem[r_wp] <= i_data;
    end
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_wp <= '0;
            r_count <= '0;
            r_wrapped <= 1'b0;
            r_full <= 1'b0;
        end else begin
            r_full <= o_full_d;
            if (w_acc) begin
                r_wp <= r_wp + AW'(1);
                if (r_count != 9'(P_DEPTH)) r_count <= r_count + 9'd1;
                if (i_mode && r_wp == AW'(P_DEPTH - 1)) r_wrapped <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/dft_capture_bank.sv
// dft_capture_bank: multi-chain scan capture buffer with capture FSM, sticky status and AXI read window
module dft_capture_bank
    import dft_capture_pkg::*;
#(
    parameter int          P_SC_NBR = 16,
    parameter int          P_DEPTH  = 64,
    parameter logic [31:0] P_BASE   = 32'h00000020
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             axi_rd_addr,
    input  logic                    axi_rd_en,
    output logic [31:0]             axi_rd_msg,
    output logic                    axi_rd_hit,
    input  logic [32*P_SC_NBR-1:0]  dft_output_data,
    input  logic [P_SC_NBR-1:0]     dft_valid,
    input  logic                    cap_start,
    input  logic                    cap_stop,
    input  logic                    cap_mode,
    input  logic [15:0]             cap_len,
    output logic                    cap_busy,
    output logic                    cap_done
);
    localparam int AW = $clog2(P_DEPTH);
    localparam logic [31:0] L_DN = word_off(P_SC_NBR, 0, P_DEPTH);
    state_t                r_state, w_state_nxt;
    logic                  r_mode, r_done, r_ovf;
    logic [8:0]            r_len;
    logic                  w_start, w_st_rd, w_in;
    logic [31:0]           w_off, w_msg, w_status;
    logic [P_SC_NBR-1:0]   w_full, w_full_d, w_wrapped, w_ovf;
    logic [31:0]           w_rd_data [P_SC_NBR];
    logic [AW-1:0]         w_wp [P_SC_NBR];
    logic [8:0]            w_count [P_SC_NBR];
    assign w_start = r_state == S_IDLE && cap_start;
    assign w_off = axi_rd_addr - P_BASE;
    assign w_in = w_off <= L_DN + 32'(P_SC_NBR);
    assign w_st_rd = axi_rd_en && w_off == L_DN;
    generate
        for (genvar g = 0; g < P_SC_NBR; g++) begin : g_lane
            dft_capture_lane #(.P_DEPTH(P_DEPTH)) u_lane (
                .clk(clk), .reset(reset), .i_clear(w_start),
                .i_capture(cap_busy), .i_mode(r_mode), .i_len(r_len),
                .i_valid(dft_valid[g]), .i_data(dft_output_data[32*g +: 32]),
                .i_rd_word(w_off[AW-1:0]), .o_rd_data(w_rd_data[g]),
                .o_wp(w_wp[g]), .o_count(w_count[g]), .o_wrapped(w_wrapped[g]),
                .o_full(w_full[g]), .o_full_d(w_full_d[g]), .o_ovf(w_ovf[g])
            );
        end
    endgenerate
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = (r_state == S_IDLE) ? (cap_start ? S_CAPTURE : S_IDLE) :
                      (r_state == S_CAPTURE) ? ((cap_stop || (!r_mode && &w_full_d)) ? S_DONE : S_CAPTURE) :
                      S_IDLE;
    end
    always_comb begin
        cap_busy = r_state == S_CAPTURE;
        cap_done = r_state == S_DONE;
    end
    // sticky flags: a set event in the clearing cycle wins over the status-read clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= 1'b0;
            r_len <= 9'(P_DEPTH);
            r_done <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_start) begin
                r_mode <= cap_mode;
                r_len <= (cap_len == 16'd0 || cap_len > 16'(P_DEPTH)) ? 9'(P_DEPTH) : cap_len[8:0];
            end
            r_done <= cap_done || (r_done && !w_st_rd);
            r_ovf <= (|w_ovf) || (r_ovf && !w_st_rd);
        end
    end
    always_comb begin
        w_status = '0;
        w_status[15:0] = 16'(w_full | w_wrapped);
        w_status[ST_BUSY] = cap_busy;
        w_status[ST_DONE] = r_done;
        w_status[ST_OVF] = r_ovf;
    end
    always_comb begin
        w_msg = '0;
        for (int i = 0; i < P_SC_NBR; i++) begin
            if (w_off < L_DN && (w_off >> AW) == 32'(i)) w_msg = w_rd_data[i];
            if (w_off == L_DN + 32'(i) + 32'd1) w_msg = {7'd0, w_count[i], 7'd0, w_wrapped[i], 8'(w_wp[i])};
        end
        if (w_off == L_DN) w_msg = w_status;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            axi_rd_msg <= '0;
            axi_rd_hit <= 1'b0;
        end else begin
            axi_rd_hit <= axi_rd_en && w_in;
            axi_rd_msg <= (axi_rd_en && w_in) ? w_msg : '0;
        end
    end
endmodule

// File: tb/tb_dft_capture_bank.sv
// tb_dft_capture_bank: directed self-checking bench for the scan capture bank
module tb_dft_capture_bank;
    localparam int NBR = 16;
    localparam int DEPTH = 64;
    localparam logic [31:0] BASE = 32'h20;
    localparam logic [31:0] S = BASE + 32'(DEPTH * NBR);
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      axi_rd_addr;
    logic             axi_rd_en;
    logic [31:0]      axi_rd_msg;
    logic             axi_rd_hit;
    logic [32*NBR-1:0] dft_output_data;
    logic [NBR-1:0]   dft_valid;
    logic             cap_start, cap_stop, cap_mode;
    logic [15:0]      cap_len;
    logic             cap_busy, cap_done;
    int               n_cmp = 0;
    int               n_err = 0;
    int               n_done = 0;
    int               done_save;
    logic [31:0]      m;
    logic             h;

    dft_capture_bank dut (
        .clk(clk), .reset(reset),
        .axi_rd_addr(axi_rd_addr), .axi_rd_en(axi_rd_en),
        .axi_rd_msg(axi_rd_msg), .axi_rd_hit(axi_rd_hit),
        .dft_output_data(dft_output_data), .dft_valid(dft_valid),
        .cap_start(cap_start), .cap_stop(cap_stop), .cap_mode(cap_mode), .cap_len(cap_len),
        .cap_busy(cap_busy), .cap_done(cap_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cap_done) n_done++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic hh);
        @(negedge clk);
        axi_rd_addr = a;
        axi_rd_en = 1'b1;
        @(negedge clk);
        d = axi_rd_msg;
        hh = axi_rd_hit;
        axi_rd_en = 1'b0;
    endtask

    task automatic rchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd(a, m, h);
        chk(tag, m, exp);
        chk({tag, "_hit"}, {31'd0, h}, 32'd1);
    endtask

    task automatic drive(input logic [NBR-1:0] v, input logic [31:0] off);
        dft_valid = v;
        for (int i = 0; i < NBR; i++) dft_output_data[32*i +: 32] = 32'h100 * i + off;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        axi_rd_addr = '0; axi_rd_en = 1'b0; dft_output_data = '0; dft_valid = '0;
        cap_start = 1'b0; cap_stop = 1'b0; cap_mode = 1'b0; cap_len = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_msg", axi_rd_msg, 32'd0);
        chk("rst_hit", {31'd0, axi_rd_hit}, 32'd0);
        chk("rst_busy", {31'd0, cap_busy}, 32'd0);
        chk("rst_done", {31'd0, cap_done}, 32'd0);
        rchk("rst_status", S, 32'd0);

        // single-shot len=4, all chains fed; the strobe in the start cycle is dropped
        @(negedge clk); cap_start = 1'b1; cap_mode = 1'b0; cap_len = 16'd4; drive('1, 32'hDEAD);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); cap_start = 1'b0; drive('1, 32'hA0 + k);
            if (k == 1) chk("ss_busy", {31'd0, cap_busy}, 32'd1);
        end
        @(negedge clk); dft_valid = '0;
        chk("ss_busy_low", {31'd0, cap_busy}, 32'd0);
        chk("ss_done_hi", {31'd0, cap_done}, 32'd1);
        @(negedge clk);
        chk("ss_done_pulse", {31'd0, cap_done}, 32'd0);
        chk("ss_done_count", n_done, 32'd1);
        for (int k = 0; k < 4; k++) rchk("ss_word", BASE + k, 32'hA0 + k);
        rchk("ss_ch5_w2", BASE + 5 * DEPTH + 2, 32'h5A2);
        rchk("ss_status", S, 32'h0002FFFF);
        rchk("ss_status2", S, 32'h0000FFFF);

        // overflow: len=2, chain 3 gets three words
        @(negedge clk); cap_start = 1'b1; cap_len = 16'd2; drive('0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); cap_start = 1'b0; drive(16'h0008, 32'h10 + k);
        end
        @(negedge clk); dft_valid = '0; cap_stop = 1'b1;
        @(negedge clk); cap_stop = 1'b0;
        rchk("ov_status", S, 32'h00060008);
        rchk("ov_status2", S, 32'h00000008);
        rchk("ov_w0", BASE + 3 * DEPTH, 32'h310);
        rchk("ov_w1", BASE + 3 * DEPTH + 1, 32'h311);
        rchk("ov_w2_old", BASE + 3 * DEPTH + 2, 32'h3A2);
        rchk("ov_ptr3", S + 4, 32'h00020002);

        // circular: chain 1 fed 0..69
        @(negedge clk); cap_start = 1'b1; cap_mode = 1'b1; cap_len = 16'd0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk); cap_start = 1'b0; dft_valid = 16'h0002; dft_output_data[63:32] = k;
        end
        @(negedge clk); dft_valid = '0; cap_stop = 1'b1;
        @(negedge clk); cap_stop = 1'b0;
        rchk("circ_ptr1", S + 2, 32'h00400106);
        rchk("circ_w0", BASE + DEPTH, 32'd64);
        rchk("circ_w5", BASE + DEPTH + 5, 32'd69);
        rchk("circ_w6", BASE + DEPTH + 6, 32'd6);
        rchk("circ_status", S, 32'h00020002);

        // address window boundaries
        rd(S + NBR + 1, m, h);
        chk("oow_hi_msg", m, 32'd0);
        chk("oow_hi_hit", {31'd0, h}, 32'd0);
        rd(BASE - 1, m, h);
        chk("oow_lo_msg", m, 32'd0);
        chk("oow_lo_hit", {31'd0, h}, 32'd0);
        rchk("win_last", S + NBR, 32'd0);
        @(negedge clk);
        chk("noen_msg", axi_rd_msg, 32'd0);
        chk("noen_hit", {31'd0, axi_rd_hit}, 32'd0);

        // reset two cycles into a capture
        @(negedge clk); cap_start = 1'b1; cap_mode = 1'b0; cap_len = 16'd4; drive('0, 0);
        @(negedge clk); cap_start = 1'b0; drive(16'h0001, 32'h55);
        @(negedge clk); drive(16'h0001, 32'h56);
        @(negedge clk); dft_valid = '0;
        chk("mid_busy_before", {31'd0, cap_busy}, 32'd1);
        done_save = n_done;
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("mid_busy_after", {31'd0, cap_busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("mid_no_done", n_done, done_save);
        rchk("mid_status", S, 32'd0);

        // start and stop together in IDLE; later start in CAPTURE is ignored
        @(negedge clk); cap_start = 1'b1; cap_stop = 1'b1; cap_mode = 1'b1;
        @(negedge clk); cap_start = 1'b0; cap_stop = 1'b0;
        chk("ss_both_busy", {31'd0, cap_busy}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            drive(16'h0004, k);
            @(negedge clk);
        end
        dft_valid = '0; cap_start = 1'b1; cap_mode = 1'b0; cap_len = 16'd1;
        @(negedge clk); cap_start = 1'b0;
        chk("restart_busy", {31'd0, cap_busy}, 32'd1);
        rchk("restart_ptr2", S + 3, 32'h00030003);
        @(negedge clk); cap_stop = 1'b1;
        @(negedge clk); cap_stop = 1'b0;
        @(negedge clk);
        chk("final_busy", {31'd0, cap_busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dft_capture_bank.md
# dft_capture_bank

Parametrised scan-chain capture buffer for the AXI pre-wrapper datapath. It generates its own per-chain write pointers and runs a capture state machine with single-shot and circular modes. It reports completion and overflow through an AXI-readable status word. It accepts up to 16 scan chains of configurable depth and answers AXI reads within its address window, so it can sit beside the opcode/state/config registers on the same read bus.

## Interface
- P_SC_NBR, 16: number of scan chains, 1..16.
- P_DEPTH, 64: words per chain, power of two, 2..256.
- P_BASE, 32'h00000020: word address of chain 0, word 0.
- clk  in  1  system clock.
- reset  in  1  reset; one clock, reset is synchronous and active-high.
- axi_rd_addr  in  32  AXI read word address.
- axi_rd_en  in  1  read request strobe.
- axi_rd_msg  out  32  read data, registered.
- axi_rd_hit  out  1  registered; 1 when the request address fell inside the block window.
- dft_output_data  in  32*P_SC_NBR  chain i word at bits [32i+31:32i].
- dft_valid  in  P_SC_NBR  per-chain word strobe.
- cap_start  in  1  start capture (pulse).
- cap_stop  in  1  end capture (pulse).
- cap_mode  in  1  0 = single-shot, 1 = circular; latched on start.
- cap_len  in  16  words per chain for single-shot; 0 or >P_DEPTH means P_DEPTH; latched on start.
- cap_busy  out  1  high in CAPTURE.
- cap_done  out  1  one-cycle pulse in DONE.

## Operation
- Address map:
  - Chain i word j is at P_BASE + P_DEPTH*i + j.
  - STATUS is at S = P_BASE + P_DEPTH*P_SC_NBR.
  - Pointer word for chain i is at S+1+i.
  - The window is [P_BASE, S+P_SC_NBR]. Any other address reads 0 with hit=0.
- STATUS bits:
  - [15:0] full/wrapped mask; bits at index ≥P_SC_NBR read 0.
  - [16] busy.
  - [17] done, sticky.
  - [18] overflow, sticky.
  - All other bits 0.
  - An AXI read of STATUS clears bits 17 and 18 on the following edge. If a set event occurs in the same cycle as the clear, set wins.
- Pointer word: [7:0] wp_i, [8] wrapped_i, [24:16] count_i (saturates at P_DEPTH).
- FSM states and transitions:
  - IDLE → CAPTURE on cap_start. On entry, all wp, count, wrapped and full bits are cleared, and mode and len are latched.
  - CAPTURE → DONE on cap_stop (either mode).
  - CAPTURE → DONE in single-shot once every chain is full.
  - DONE → IDLE unconditionally after one cycle. DONE sets sticky done.
- Capture in CAPTURE: each chain with dft_valid[i] writes mem_i[wp_i] and increments wp_i modulo P_DEPTH. Chains are fully independent.
- Single-shot: chain i is full when count_i == len. A valid strobe on a full chain is dropped and sets overflow.
- Circular: writes never stop. Crossing the wrap point sets wrapped_i and the mask bit, and the oldest word is at wp_i. Overflow is never set.
- Boundary rules:
  - cap_start in CAPTURE or DONE: ignored.
  - cap_stop in IDLE or DONE: ignored.
  - cap_start and cap_stop together in IDLE: start wins.
  - dft_valid outside CAPTURE: ignored.
  - Buffer memory is not reset; only words written since start are defined.

## Timing
- Reset values: axi_rd_msg=0, axi_rd_hit=0, cap_busy=0, cap_done=0. State is IDLE; all pointers, counts and flags are 0.
- Read latency is 1 cycle: address and en are sampled at edge N, and msg/hit are valid after edge N. Without en, msg and hit hold 0.
- A read of word j in the same cycle as a write to word j returns the old data.
- A write with the valid strobe on the cycle cap_start is sampled (IDLE) is dropped. The first accepted word is on the cycle after start.
- Single-shot completion: the last write edge moves the FSM to DONE. cap_done is high the following cycle and cap_busy drops at that same edge.
- Reset asserted mid-capture returns the block to IDLE at the next edge with flags cleared. No cap_done is produced.

## Structure
- Package dft_capture_pkg holds:
  - the state encoding (IDLE, CAPTURE, DONE);
  - the STATUS bit indices;
  - the address offset constants and helper function (chain/word → offset).
- Sub-module dft_capture_lane, instantiated P_SC_NBR times via generate, contains one chain's:
  - memory;
  - wp, count, wrapped and full logic;
  - overflow pulse output.
- The top level holds the FSM, the sticky flags and the read decode/mux.

## Test plan
- Single-shot, len=4, chain 0 fed 0xA0..0xA3, remaining chains fed 4 words each:
  - cap_done fires once.
  - Reading P_BASE+0..3 returns 0xA0..0xA3.
  - STATUS reads 0x0002FFFF (P_SC_NBR=16).
- Overflow: single-shot len=2, chain 3 fed 3 words, then cap_stop:
  - STATUS bit18=1 and chain 3 word 2 is unwritten.
  - A second STATUS read shows bits 17 and 18 = 0.
- Circular, P_DEPTH=64, chain 1 fed 70 words 0..69, then cap_stop:
  - Pointer word at S+2 = 0x00400106.
  - Word P_BASE+64+0 reads 64.
- Reads with address S+P_SC_NBR+1 or P_BASE-1 → msg=0, hit=0.
- Reset asserted 2 cycles into capture → busy=0 and no cap_done. STATUS=0 after reset.
- Start and stop together in IDLE → CAPTURE entered. Start during CAPTURE does not clear pointers.
